// File: rtl/display_scan_if.sv
// display_scan_if: value/mask/load inputs and segment/anode/status outputs of the scan controller
interface display_scan_if;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic        load;
    logic [0:6]  sevenSeg;
    logic [3:0]  AN;
    logic        pending;
    logic        frame_done;

    modport master (
        output value, digit_en, load,
        input  sevenSeg, AN, pending, frame_done
    );

    modport slave (
        input  value, digit_en, load,
        output sevenSeg, AN, pending, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit 7-segment scan scheduler with per-slot dead-time and frame-synchronous value update
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading-zero digits when defined)
module display_scan_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic          CLK100MHZ,
    input  logic          reset_n,
    display_scan_if.slave bus
);
    localparam int TICK_DIV = CLK_HZ / REFRESH_HZ;
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, ON} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   staging_q, shadow_q;
    logic          pending_q;
    logic [3:0]    an_q, an_d;
    logic [0:6]    seg_q, seg_d;
    logic [3:0]    nib;
    logic [3:0]    visible;
    logic          slot_end;
    logic          wrap;

    function automatic logic [0:6] hex7(input logic [3:0] h);
        case (h)
            4'h0:    hex7 = 7'b0000001;
            4'h1:    hex7 = 7'b1001111;
            4'h2:    hex7 = 7'b0010010;
            4'h3:    hex7 = 7'b0000110;
            4'h4:    hex7 = 7'b1001100;
            4'h5:    hex7 = 7'b0100100;
            4'h6:    hex7 = 7'b0100000;
            4'h7:    hex7 = 7'b0001111;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0000100;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b1100000;
            4'hC:    hex7 = 7'b0110001;
            4'hD:    hex7 = 7'b1000010;
            4'hE:    hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    assign visible = bus.digit_en & {|shadow_q[15:12], |shadow_q[15:8], |shadow_q[15:4], 1'b1};
`else
    assign visible = bus.digit_en;
`endif

    assign nib      = shadow_q[{idx_q, 2'b00} +: 4];
    assign slot_end = (state_q == ON) && (cnt_q == SLOT_LAST);
    assign wrap     = slot_end && (idx_q == 2'd3);

    assign bus.AN         = an_q;
    assign bus.sevenSeg   = seg_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = wrap;

    // Slot timing: one counter spans the whole slot, BLANK covers its first BLANK_CYCLES counts
    always_comb begin
        state_d = state_q;
        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        if (state_q == BLANK && cnt_q == BLANK_LAST) begin
            state_d = ON;
            an_d    = visible[idx_q] ? ~(4'b0001 << idx_q) : 4'b1111;
            seg_d   = visible[idx_q] ? hex7(nib) : 7'b1111111;
        end else if (slot_end) begin
            state_d = BLANK;
            idx_d   = idx_q + 2'd1;
            an_d    = 4'b1111;
            seg_d   = 7'b1111111;
        end
    end

    // State, slot counter, digit index and registered display drive
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    // Loads are staged and only promoted to the shadow copy on the frame wrap, so a frame never tears
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            staging_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else if (wrap) begin
            shadow_q  <= bus.load ? bus.value : (pending_q ? staging_q : shadow_q);
            pending_q <= 1'b0;
        end else if (bus.load) begin
            staging_q <= bus.value;
            pending_q <= 1'b1;
        end
    end
endmodule
